// File: rtl/spi_serializer_gen.sv
// SPI master transmit serializer fed from a show-ahead FIFO (CPHA=0, CPOL/bit order configurable).
// Optional MISO capture path enabled by defining SPI_MISO_CAPTURE_EN.
module spi_serializer_gen #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CLK_DIV    = 2,
  parameter bit          LSB_FIRST  = 1'b0,
  parameter bit          CPOL       = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  empty,
  input  logic [DATA_WIDTH-1:0] read_data,
`ifdef SPI_MISO_CAPTURE_EN
  input  logic                  miso,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
`endif
  output logic                  read_en,
  output logic                  sclk,
  output logic                  mosi,
  output logic                  cs_n,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned BCW = $clog2(DATA_WIDTH + 1);
  localparam logic [BCW-1:0] BC_FULL  = BCW'(DATA_WIDTH);
  localparam logic [BCW-1:0] BC_LAST  = BCW'(1);
  localparam logic [7:0]     DIV_LAST = 8'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    COMPLETE
  } state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [BCW-1:0]        bit_counter;
  logic [7:0]            div_cnt;

  logic                  first_bit;
  logic                  next_bit;
  logic [DATA_WIDTH-1:0] shifted;
  logic                  div_wrap;

`ifdef SPI_MISO_CAPTURE_EN
  logic [DATA_WIDTH-1:0] rx_shift;
  logic [DATA_WIDTH-1:0] rx_next;
`endif

  // Output end of the shift register depends on bit order; the register
  // always moves toward that end so the next bit is its neighbour.
  always_comb begin
    if (LSB_FIRST) begin
      first_bit = read_data[0];
      next_bit  = shift_reg[1];
      shifted   = shift_reg >> 1;
    end else begin
      first_bit = read_data[DATA_WIDTH-1];
      next_bit  = shift_reg[DATA_WIDTH-2];
      shifted   = shift_reg << 1;
    end
  end

`ifdef SPI_MISO_CAPTURE_EN
  always_comb begin
    if (LSB_FIRST) rx_next = {miso, rx_shift[DATA_WIDTH-1:1]};
    else           rx_next = {rx_shift[DATA_WIDTH-2:0], miso};
  end
`endif

  assign div_wrap = (div_cnt == DIV_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      read_en     <= 1'b0;
      done        <= 1'b0;
      busy        <= 1'b0;
      cs_n        <= 1'b1;
      sclk        <= CPOL;
      mosi        <= 1'b0;
      shift_reg   <= '0;
      bit_counter <= '0;
      div_cnt     <= '0;
`ifdef SPI_MISO_CAPTURE_EN
      rx_shift    <= '0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
`endif
    end else begin
      read_en  <= 1'b0;
      done     <= 1'b0;
`ifdef SPI_MISO_CAPTURE_EN
      rx_valid <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (!empty) begin
            state   <= LOAD;
            read_en <= 1'b1;
            busy    <= 1'b1;
            cs_n    <= 1'b0;
          end
        end

        LOAD: begin
          state       <= SHIFT;
          shift_reg   <= read_data;
          mosi        <= first_bit;
          bit_counter <= BC_FULL;
          div_cnt     <= '0;
        end

        SHIFT: begin
          if (div_wrap) begin
            div_cnt <= '0;
            sclk    <= ~sclk;
            if (sclk == CPOL) begin
              // Leading edge: slave samples here, so mosi must stay put.
`ifdef SPI_MISO_CAPTURE_EN
              rx_shift <= rx_next;
`endif
            end else begin
              shift_reg   <= shifted;
              mosi        <= next_bit;
              bit_counter <= bit_counter - 1'b1;
              if (bit_counter == BC_LAST) begin
                state <= COMPLETE;
                done  <= 1'b1;
`ifdef SPI_MISO_CAPTURE_EN
                rx_data  <= rx_shift;
                rx_valid <= 1'b1;
`endif
              end
            end
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end

        COMPLETE: begin
          if (!empty) begin
            state   <= LOAD;
            read_en <= 1'b1;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
            cs_n  <= 1'b1;
            mosi  <= 1'b0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
